// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with registered Empty/Full flags (optional FIFO_ERR_EN error flags)
module sync_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Din,
    input  logic             WR_EN,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] Dout,
    output logic             Empty,
`ifdef FIFO_ERR_EN
    output logic             Full,
    output logic             Overflow,
    output logic             Underflow
`else
    output logic             Full
`endif
);

    localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;

    logic              wr_ok;
    logic              rd_ok;

    // Requests are qualified against the registered flags, so a simultaneous
    // request on an empty FIFO degenerates to write-only and on a full FIFO to read-only.
    always_comb begin
        wr_ok = WR_EN && !full_q;
        rd_ok = RD_EN && !empty_q;
    end

    // Next-state for pointers, occupancy, read data and flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = mem[rd_ptr_q];
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= Din;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign Dout  = dout_q;
    assign Empty = empty_q;
    assign Full  = full_q;

`ifdef FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: once a rejected request is seen it stays flagged until reset.
    always_comb begin
        overflow_d  = overflow_q  || (WR_EN && full_q);
        underflow_d = underflow_q || (RD_EN && empty_q);
    end

    // Error flag registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - randomized queue-model bench for sync_fifo
`timescale 1ns/1ps
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [WIDTH-1:0] Din = '0;
    logic             WR_EN = 1'b0;
    logic             RD_EN = 1'b0;
    logic [WIDTH-1:0] Dout;
    logic             Empty;
    logic             Full;
`ifdef FIFO_ERR_EN
    logic             Overflow;
    logic             Underflow;
`endif

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Din      (Din),
        .WR_EN    (WR_EN),
        .RD_EN    (RD_EN),
        .Dout     (Dout),
        .Empty    (Empty),
`ifdef FIFO_ERR_EN
        .Full     (Full),
        .Overflow (Overflow),
        .Underflow(Underflow)
`else
        .Full     (Full)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Behavioural model: a queue of held bytes plus the last byte read out.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_dout = '0;
    bit               m_ovf  = 1'b0;
    bit               m_udf  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            int sz;
            sz = m_q.size();
            if (WR_EN && sz == DEPTH) m_ovf = 1'b1;
            if (RD_EN && sz == 0)     m_udf = 1'b1;
            if (RD_EN && sz > 0)      m_dout = m_q.pop_front();
            if (WR_EN && sz < DEPTH)  m_q.push_back(Din);
        end
    end

    // Compare process: every negedge once checking is armed.
    always @(negedge CLK) begin
        if (check_en) begin
            chk("dout",  int'(Dout),  int'(m_dout));
            chk("empty", int'(Empty), int'(m_q.size() == 0));
            chk("full",  int'(Full),  int'(m_q.size() == DEPTH));
`ifdef FIFO_ERR_EN
            chk("overflow",  int'(Overflow),  int'(m_ovf));
            chk("underflow", int'(Underflow), int'(m_udf));
`endif
        end
    end

    // Drive at a negedge, let one rising edge sample it, return 1ns after that edge.
    task automatic step(input bit wr, input bit rd, input logic [WIDTH-1:0] d);
        WR_EN = wr;
        RD_EN = rd;
        Din   = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic to_negedge();
        @(negedge CLK);
        WR_EN = 1'b0;
        RD_EN = 1'b0;
    endtask

    initial begin
        int written;
        int guard;
        logic [WIDTH-1:0] last;

        // Reset then idle
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dout", int'(Dout), 0);
        chk("rst_empty", int'(Empty), 1);
        chk("rst_full", int'(Full), 0);
        @(negedge CLK);
        RST = 1'b1;
        check_en = 1'b1;
        step(0, 0, 8'h00); to_negedge();
        step(0, 0, 8'h00); to_negedge();
        chk("idle_empty", int'(Empty), 1);
        chk("idle_dout", int'(Dout), 0);

        // Fill
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(i));
            if (i == 0) chk("fill_first_empty", int'(Empty), 0);
            if (i == DEPTH - 2) chk("fill_15_full", int'(Full), 0);
            if (i == DEPTH - 1) chk("fill_16_full", int'(Full), 1);
            to_negedge();
        end
        chk("model_size_full", m_q.size(), DEPTH);
        step(1, 0, 8'd16);
        chk("overfill_full", int'(Full), 1);
`ifdef FIFO_ERR_EN
        chk("overfill_ovf", int'(Overflow), 1);
`endif
        to_negedge();
        chk("model_size_after_drop", m_q.size(), DEPTH);

        // Drain
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 8'h00);
            chk("drain_dout", int'(Dout), i);
            if (i == DEPTH - 1) chk("drain_last_empty", int'(Empty), 1);
            else                chk("drain_not_empty", int'(Empty), 0);
            to_negedge();
        end
        step(0, 1, 8'h00);
        chk("underread_dout", int'(Dout), 15);
`ifdef FIFO_ERR_EN
        chk("underread_udf", int'(Underflow), 1);
`endif
        to_negedge();

        // Wrap-around: 257 bytes 0..255,0 with random interleaved reads
        written = 0;
        guard = 0;
        while ((written < 257 || m_q.size() > 0) && guard < 5000) begin
            bit w, r;
            w = (written < 257) && (m_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            r = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            step(w, r, 8'(written));
            if (w) written++;
            to_negedge();
            guard++;
        end
        chk("wrap_done_in_budget", int'(guard < 5000), 1);
        chk("wrap_last_byte", int'(Dout), 0);
        chk("wrap_empty", int'(Empty), 1);

        // Simultaneous enables with 5 held
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 8'(8'h10 + i)); to_negedge();
        end
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 8'(8'h20 + k));
            chk("both_dout", int'(Dout), 8'h10 + k);
            to_negedge();
        end
        chk("both_model_size", m_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'h00); to_negedge();
        end
        chk("both_drain_dout", int'(Dout), 8'h22);
        chk("both_drain_empty", int'(Empty), 1);

        // Both enables while empty: write only
        last = Dout;
        step(1, 1, 8'h77);
        chk("empty_both_dout", int'(Dout), int'(last));
        chk("empty_both_empty", int'(Empty), 0);
        to_negedge();
        step(0, 1, 8'h00);
        chk("empty_both_readback", int'(Dout), 8'h77);
        to_negedge();

        // Reset mid-operation with 8 held
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 8'(8'h40 + i)); to_negedge();
        end
        step(0, 1, 8'h00); to_negedge();
        chk("pre_reset_dout", int'(Dout), 8'h40);
        #2;
        RST = 1'b0;
        #1;
        chk("midrst_empty", int'(Empty), 1);
        chk("midrst_dout", int'(Dout), 0);
        chk("midrst_full", int'(Full), 0);
        #1;
        RST = 1'b1;
        to_negedge();
        step(1, 0, 8'hA5); to_negedge();
        step(0, 1, 8'h00);
        chk("post_reset_a5", int'(Dout), 8'hA5);
        to_negedge();

        // Free-running random traffic, including rejected requests
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            to_negedge();
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
